// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and IDLE/ACCESS/RESP sequencer in front of a single-ported data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins ties).
module dmem_arbiter #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_we_q, cmd_we_d;
  logic        cmd_err_q, cmd_err_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        grant_q, grant_d;
  logic [31:0] rdata_q, rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic        last_grant_q, last_grant_d;
`endif

  logic        winner;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_illegal;
  logic        access_legal;
  logic        resp;

  // Winner selection: a lone requester always wins; ties go to the port not served last.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    winner = ~req0;
`else
    winner = (req0 & req1) ? ~last_grant_q : req1;
`endif
    win_we      = winner ? we1 : we0;
    win_addr    = winner ? addr1 : addr0;
    win_wdata   = winner ? wdata1 : wdata0;
    win_illegal = (win_addr[1:0] != 2'b00) || (win_addr[31:2] >= 30'(MEM_WORDS));
  end

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_err_d   = cmd_err_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    grant_d     = grant_q;
    rdata_d     = rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          cmd_we_d    = win_we;
          cmd_err_d   = win_illegal;
          cmd_addr_d  = win_addr;
          cmd_wdata_d = win_wdata;
          grant_d     = winner;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        rdata_d = (!cmd_we_q && !cmd_err_q) ? memReadData : 32'h0;
        state_d = StResp;
      end
      StResp: begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant_d = grant_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_addr_q  <= 32'h0;
      cmd_wdata_q <= 32'h0;
      grant_q     <= 1'b0;
      rdata_q     <= 32'h0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_err_q   <= cmd_err_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      grant_q     <= grant_d;
      rdata_q     <= rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Write enable is gated by reset so an interrupted access never commits.
  always_comb begin
    access_legal = (state_q == StAccess) && !cmd_err_q;
    MemRead      = access_legal & ~cmd_we_q;
    MemWrite     = access_legal & cmd_we_q & ~reset;
    memAddress   = cmd_addr_q;
    memWriteData = cmd_wdata_q;
    resp         = (state_q == StResp);
    ack0         = resp & ~grant_q;
    ack1         = resp & grant_q;
    err0         = ack0 & cmd_err_q;
    err1         = ack1 & cmd_err_q;
    rdata0       = ack0 ? rdata_q : 32'h0;
    rdata1       = ack1 ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected acks, a negedge monitor checks them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        MemRead, MemWrite;
  logic [31:0] memAddress, memWriteData, memReadData;

  dmem_arbiter #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .memAddress(memAddress), .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  // Memory model: word i initialised to 0xA500_0000 | i.
  logic [31:0] mem [64];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (MemWrite) begin
      mem[memAddress[7:2]] <= memWriteData;
    end
  end
  assign memReadData = mem[memAddress[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_count = 0;
  logic [31:0] wr_addr = 32'h0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int port, input logic err, input logic [31:0] rdata, input int at);
    exp_t e;
    e.port = port; e.err = err; e.rdata = rdata; e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (MemWrite) begin
          wr_count++;
          wr_addr = memAddress;
        end
        if (MemRead && MemWrite) chk("rd_wr_exclusive", 32'(MemWrite), 32'h0);
        if (ack0 || ack1) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack: got ack0=%b ack1=%b want none (cycle %0d)",
                     ack0, ack1, cyc);
          end else begin
            e = sb.pop_front();
            chk("ack_port", {30'h0, ack1, ack0}, (e.port == 1) ? 32'h2 : 32'h1);
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("err", 32'(ack1 ? err1 : err0), 32'(e.err));
            chk("rdata", ack1 ? rdata1 : rdata0, e.rdata);
            chk("other_port_zero", ack1 ? ({31'h0, err0} | rdata0) : ({31'h0, err1} | rdata1),
                32'h0);
          end
        end
      end
    end
  end

  task automatic wait_ack(input int port);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((port == 0) ? ack0 : ack1) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack on port %0d want ack within 20 cycles", port);
    end
  endtask

  task automatic access(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    push(port, exp_err, exp_rdata, cyc + 2);
    if (port == 0) begin
      we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
    end else begin
      we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
    end
    wait_ack(port);
    @(posedge clk); #1;
    if (port == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int wc0;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ack0), 32'h0);
    chk("rst_ack1", 32'(ack1), 32'h0);
    chk("rst_err", {30'h0, err1, err0}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_mem_en", {30'h0, MemWrite, MemRead}, 32'h0);
    chk("rst_memaddr", memAddress, 32'h0);
    chk("rst_memwdata", memWriteData, 32'h0);
    reset = 1'b0;
    mem_init = 1'b0;
    mon_en = 1'b1;

    // Simultaneous requests held for four accesses.
    @(posedge clk); #1;
    k = cyc;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    push(0, 1'b0, 32'hA500_0004, k + 2);
    push(0, 1'b0, 32'hA500_0004, k + 5);
    push(0, 1'b0, 32'hA500_0004, k + 8);
    push(0, 1'b0, 32'hA500_0004, k + 11);
`else
    push(0, 1'b0, 32'hA500_0004, k + 2);
    push(1, 1'b0, 32'hA500_0000, k + 5);
    push(0, 1'b0, 32'hA500_0004, k + 8);
    push(1, 1'b0, 32'hA500_0000, k + 11);
`endif
    we0 = 0; addr0 = 32'h10; req0 = 1;
    we1 = 0; addr1 = 32'h0;  req1 = 1;
    repeat (12) @(posedge clk);
    #1;
    req0 = 0; req1 = 0;
    chk("tie_no_writes", 32'(wr_count), 32'h0);

    // Single write then read.
    wc0 = wr_count;
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    chk("wr_once", 32'(wr_count - wc0), 32'h1);
    chk("wr_addr", wr_addr, 32'h10);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Illegal addresses from port 1: misaligned and out of range.
    wc0 = wr_count;
    access(1, 1'b1, 32'h102, 32'h1234_5678, 1'b1, 32'h0);
    access(1, 1'b1, 32'h100, 32'h1234_5678, 1'b1, 32'h0);
    chk("illegal_no_write", 32'(wr_count - wc0), 32'h0);
    access(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA500_0000);
    access(1, 1'b0, 32'hFC, 32'h0, 1'b0, 32'hA500_003F);

    // Reset during ACCESS of a write to 0x20.
    wc0 = wr_count;
    @(posedge clk); #1;
    we0 = 1; addr0 = 32'h20; wdata0 = 32'hCAFE_F00D; req0 = 1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_access_memwrite", 32'(MemWrite), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    req0 = 0;
    chk("rst_access_memaddr", memAddress, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_access_no_write", 32'(wr_count - wc0), 32'h0);
    access(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA500_0008);

    // Held request treated as a new request after ack.
    @(posedge clk); #1;
    k = cyc;
    push(0, 1'b0, 32'hDEAD_BEEF, k + 2);
    push(0, 1'b0, 32'hDEAD_BEEF, k + 5);
    we0 = 0; addr0 = 32'h10; req0 = 1;
    repeat (6) @(posedge clk);
    #1;
    req0 = 0;

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
